// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// alu_pkg : shared ALU opcodes, divider state encoding and default width.
// Revision: 1.0
// ============================================================================
package alu_pkg;

    localparam logic [5:0] MULTU = 6'b011001;
    localparam logic [5:0] DIVU  = 6'b011011;
    localparam logic [5:0] FIRST = 6'b111110;
    localparam logic [5:0] OUT   = 6'b111111;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } divu_state_e;

endpackage
`default_nettype wire

// File: rtl/divu_step.sv
`default_nettype none
// ============================================================================
// divu_step : one restoring shift-subtract iteration (one quotient bit).
// Revision: 1.0
// ============================================================================
module divu_step
    import alu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem_next,
    output logic [WIDTH-1:0] o_quo_next
);

    logic [WIDTH:0] w_trial;

    // Extra MSB of the subtraction is the borrow: set means the divisor did not fit.
    assign w_trial = {i_rem, i_quo[WIDTH-1]} - {1'b0, i_divisor};

    always_comb begin
        if (w_trial[WIDTH] == 1'b0) begin
            o_rem_next = w_trial[WIDTH-1:0];
            o_quo_next = {i_quo[WIDTH-2:0], 1'b1};
        end else begin
            o_rem_next = {i_rem[WIDTH-2:0], i_quo[WIDTH-1]};
            o_quo_next = {i_quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule
`default_nettype wire

// File: rtl/divu_unit.sv
`default_nettype none
// ============================================================================
// divu_unit : sequential unsigned divider, one quotient bit per clock,
//             result packed {remainder, quotient} like the multiplier HI/LO.
// Revision: 1.0
// ============================================================================
module divu_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     dataA,
    input  logic [WIDTH-1:0]     dataB,
    output logic                 busy,
    output logic                 done,
    output logic                 div_zero,
    output logic [2*WIDTH-1:0]   dataOut
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    divu_state_e        r_state;
    divu_state_e        w_next_state;
    logic [CNT_W-1:0]   r_count;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_divisor;
    logic               r_done;
    logic               r_div_zero;
    logic [2*WIDTH-1:0] r_data_out;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quo_next;
    logic               w_last;
    logic               w_b_zero;

    assign w_last   = (r_count == CNT_W'(WIDTH - 1));
    assign w_b_zero = (dataB == '0);

    divu_step #(.WIDTH(WIDTH)) u_step (
        .i_rem      (r_rem),
        .i_quo      (r_quo),
        .i_divisor  (r_divisor),
        .o_rem_next (w_rem_next),
        .o_quo_next (w_quo_next)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = w_b_zero ? DONE : CALC;
            CALC:    if (w_last) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count    <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_divisor  <= '0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            r_data_out <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_divisor  <= dataB;
                        r_count    <= '0;
                        r_div_zero <= 1'b0;
                        // Zero divisor skips the iterations with the conventional all-ones quotient.
                        if (w_b_zero) begin
                            r_rem <= dataA;
                            r_quo <= '1;
                        end else begin
                            r_rem <= '0;
                            r_quo <= dataA;
                        end
                    end
                end
                CALC: begin
                    r_rem   <= w_rem_next;
                    r_quo   <= w_quo_next;
                    r_count <= r_count + 1'b1;
                end
                DONE: begin
                    r_done     <= 1'b1;
                    r_data_out <= {r_rem, r_quo};
                    r_div_zero <= (r_divisor == '0);
                end
                default: ;
            endcase
        end
    end

    assign done     = r_done;
    assign div_zero = r_div_zero;
    assign dataOut  = r_data_out;

endmodule
`default_nettype wire

// File: tb/tb_divu_unit.sv
`default_nettype none
// ============================================================================
// tb_divu_unit : directed table, reset/ignored-start sequences and random
//                operands checked against plain a/b, a%b arithmetic.
// Revision: 1.0
// ============================================================================
module tb_divu_unit;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [63:0] dataOut;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    divu_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .dataA    (dataA),
        .dataB    (dataB),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .dataOut  (dataOut)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one division, optionally poking start during CALC and DONE, and check everything.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input bit poke);
        int          cyc;
        int          busyc;
        logic [31:0] eq;
        logic [31:0] er;
        logic        edz;
        if (b == 0) begin
            eq = 32'hFFFF_FFFF; er = a; edz = 1'b1;
        end else begin
            eq = a / b; er = a % b; edz = 1'b0;
        end
        @(negedge clk);
        dataA = a; dataB = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dataA = $urandom; dataB = $urandom;
        chk("dz_clear_on_accept", 64'(div_zero), 64'd0);
        cyc = 1; busyc = 0;
        while (!done && cyc < 60) begin
            if (busy) busyc++;
            if (poke && (cyc == 5 || cyc == 33)) begin
                start = 1'b1; dataA = 32'd99; dataB = 32'd9;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("done_seen", 64'(done), 64'd1);
        chk("latency_edges", 64'(cyc - 1), (b == 0) ? 64'd1 : 64'd33);
        chk("busy_cycles", 64'(busyc), (b == 0) ? 64'd1 : 64'd33);
        chk("busy_at_done", 64'(busy), 64'd0);
        chk("result", dataOut, {er, eq});
        chk("div_zero", 64'(div_zero), 64'(edz));
        @(negedge clk);
        chk("done_width", 64'(done), 64'd0);
        chk("result_hold", dataOut, {er, eq});
    endtask

    vec_t tbl[9];

    initial begin
        tbl[0] = '{32'd100,        32'd7,  32'd14,         32'd2, 1'b0};
        tbl[1] = '{32'hFFFF_FFFF,  32'd1,  32'hFFFF_FFFF,  32'd0, 1'b0};
        tbl[2] = '{32'd3,          32'd10, 32'd0,          32'd3, 1'b0};
        tbl[3] = '{32'd5,          32'd0,  32'hFFFF_FFFF,  32'd5, 1'b1};
        tbl[4] = '{32'd8,          32'd2,  32'd4,          32'd0, 1'b0};
        tbl[5] = '{32'd1000,       32'd3,  32'd333,        32'd1, 1'b0};
        tbl[6] = '{32'd0,          32'd5,  32'd0,          32'd0, 1'b0};
        tbl[7] = '{32'd7,          32'd7,  32'd1,          32'd0, 1'b0};
        tbl[8] = '{32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'd1,   32'd1, 1'b0};

        reset = 1'b1; start = 1'b0; dataA = '0; dataB = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_div_zero", 64'(div_zero), 64'd0);
        chk("rst_dataOut", dataOut, 64'd0);
        reset = 1'b0;

        // Table entries carry hand-computed results; run_div also checks against arithmetic.
        for (int i = 0; i < 9; i++) begin
            run_div(tbl[i].a, tbl[i].b, 1'b0);
            chk("tbl_result", dataOut, {tbl[i].r, tbl[i].q});
            chk("tbl_div_zero", 64'(div_zero), 64'(tbl[i].dz));
        end

        // Reset in the middle of CALC discards everything.
        @(negedge clk);
        dataA = 32'd1000; dataB = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_div_zero", 64'(div_zero), 64'd0);
        chk("midrst_dataOut", dataOut, 64'd0);
        repeat (3) @(negedge clk);
        chk("midrst_idle_busy", 64'(busy), 64'd0);
        run_div(32'd1000, 32'd3, 1'b0);
        chk("restart_result", dataOut, {32'd1, 32'd333});

        // Start pulses while busy must not re-capture or queue.
        run_div(32'd50, 32'd5, 1'b1);
        chk("poke_result", dataOut, {32'd0, 32'd10});
        begin
            int extra = 0;
            int busy_seen = 0;
            repeat (40) begin
                @(negedge clk);
                if (done) extra++;
                if (busy) busy_seen++;
            end
            chk("poke_no_second_done", 64'(extra), 64'd0);
            chk("poke_no_requeue", 64'(busy_seen), 64'd0);
        end

        for (int n = 0; n < 1500; n++) begin
            logic [31:0] a;
            logic [31:0] b;
            case ($urandom_range(0, 5))
                0: begin a = $urandom; b = 32'd1; end
                1: begin a = $urandom_range(0, 1000); b = a + 32'd1 + $urandom_range(0, 1000); end
                2: begin a = 32'd0; b = $urandom; end
                3: begin a = $urandom; b = $urandom_range(0, 17); end
                default: begin a = $urandom; b = $urandom >> $urandom_range(0, 31); end
            endcase
            run_div(a, b, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
